// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file with scoreboard.
// Holds the sweep FSM state encoding.
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } sweep_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits with issue/write-clear/flush priority.
// Bit 0 is never pending.
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_iss,
  input  logic [AW-1:0]   i_iss_addr,
  input  logic [NREG-1:0] i_clr,
  input  logic            i_flush,
  output logic [NREG-1:0] o_busy
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nx;

  // Issue beats a same-cycle clear; flush beats everything.
  always_comb begin
    w_busy_nx = r_busy & ~i_clr;
    if (i_iss)
      w_busy_nx[i_iss_addr] = 1'b1;
    if (i_flush)
      w_busy_nx = '0;
    w_busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_busy <= '0;
    else
      r_busy <= w_busy_nx;
  end

  assign o_busy = r_busy;
endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass, busy scoreboard
// and a sweep-clear FSM that zeroes r1..r(NREG-1).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRP    = 2,
  parameter int NWP    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRP*AW-1:0] rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]    rd_busy,
  input  logic [NWP-1:0]    wr_en,
  input  logic [NWP*AW-1:0] wr_addr,
  input  logic [NWP*XLEN-1:0] wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);
  sweep_e          r_state;
  sweep_e          w_state_nx;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nx;
  logic            w_idle;
  logic            w_done;
  logic [XLEN-1:0] r_regs [NREG];
  logic [NWP-1:0]  w_we;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_busy;
  logic            w_iss;
  logic [AW-1:0]   w_ra;
  logic [NRP-1:0]  w_hit;

  assign w_idle = (r_state == S_IDLE);

  // Write ports are dead while sweeping.
  always_comb begin
    w_we = '0;
    for (int w = 0; w < NWP; w++)
      w_we[w] = wr_en[w] && w_idle &&
                (wr_addr[w*AW +: AW] != '0);
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nx = S_CLEAR;
          w_cnt_nx   = AW'(1);
        end
      end
      S_CLEAR: begin
        w_cnt_nx = r_cnt + 1'b1;
        if (r_cnt == AW'(NREG - 1)) begin
          w_state_nx = S_IDLE;
          w_done     = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Ascending port loop: the highest port wins a shared address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else begin
      for (int w = 0; w < NWP; w++)
        if (w_we[w])
          r_regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      if (!w_idle)
        r_regs[r_cnt] <= '0;
    end
  end

  always_comb begin
    w_clr = '0;
    for (int w = 0; w < NWP; w++)
      if (w_we[w])
        w_clr[wr_addr[w*AW +: AW]] = 1'b1;
    if (!w_idle)
      w_clr[r_cnt] = 1'b1;
  end

  assign w_iss = iss_en && w_idle && (iss_addr != '0);

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_iss      (w_iss),
    .i_iss_addr (iss_addr),
    .i_clr      (w_clr),
    .i_flush    (flush),
    .o_busy     (w_busy)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    w_hit   = '0;
    w_ra    = '0;
    for (int p = 0; p < NRP; p++) begin
      w_ra = rd_addr[p*AW +: AW];
      if (w_ra != '0)
        rd_data[p*XLEN +: XLEN] = r_regs[w_ra];
      if (BYPASS != 0 && w_ra != '0)
        for (int w = 0; w < NWP; w++)
          if (w_we[w] && wr_addr[w*AW +: AW] == w_ra) begin
            rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
            w_hit[p] = 1'b1;
          end
      rd_busy[p] = w_busy[w_ra] && !w_hit[p];
    end
  end

  assign clr_busy = !w_idle;
  assign clr_done = w_done;
endmodule
